// File: rtl/thunder_pkg.sv
// Purpose: shared TSIP framing constants, field offsets, FSM encoding and time-field struct.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package thunder_pkg;

   localparam logic [7:0] DLE              = 8'h10;
   localparam logic [7:0] ETX              = 8'h03;
   localparam logic [7:0] TSIP_ID_TIMING   = 8'h8F;
   localparam logic [7:0] TSIP_SUB_PRIMARY = 8'hAB;

   localparam int PRIMARY_LEN = 17;
   localparam int IDX_MAX     = 31;

   localparam int OFS_SUB     = 0;
   localparam int OFS_SEC     = 10;
   localparam int OFS_MIN     = 11;
   localparam int OFS_HOUR    = 12;
   localparam int OFS_DAY     = 13;
   localparam int OFS_MONTH   = 14;
   localparam int OFS_YEAR_HI = 15;
   localparam int OFS_YEAR_LO = 16;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ID,
      ST_BODY,
      ST_BODY_DLE,
      ST_SKIP,
      ST_SKIP_DLE
   } tsip_state_t;

   typedef struct packed {
      logic [15:0] year;
      logic [7:0]  month;
      logic [7:0]  day;
      logic [7:0]  hour;
      logic [7:0]  minutes;
      logic [7:0]  seconds;
   } thunder_time_t;

`ifdef THUNDER_RANGE_CHECK_EN
   // Calendar sanity test applied to a candidate packet before it is published.
   function automatic logic time_in_range(input thunder_time_t t);
      return (t.month >= 8'd1) && (t.month <= 8'd12) &&
             (t.day >= 8'd1) && (t.day <= 8'd31) &&
             (t.hour <= 8'd23) && (t.minutes <= 8'd59) &&
             (t.seconds <= 8'd60) && (t.year >= 16'd2000);
   endfunction
`endif

endpackage

// File: rtl/tsip_frame_unstuffer.sv
// Purpose: TSIP DLE/ETX framing FSM; strips byte stuffing and flags start/end/resync of 0x8F frames.
// Latency: combinational strobes in the cycle the byte is presented; state advances on the next edge.
// Backpressure: none; a byte is consumed in every cycle i_rx_dv is high, i_abort forces IDLE.
module tsip_frame_unstuffer
   import thunder_pkg::*;
(
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_rx_dv,
   input  logic [7:0] i_rx_byte,
   input  logic       i_abort,
   output logic       o_data_dv,
   output logic [7:0] o_data,
   output logic       o_sof,
   output logic       o_eof,
   output logic       o_err,
   output logic       o_busy,
   output logic       o_in_body
);

   tsip_state_t r_state;
   tsip_state_t w_state_nxt;

   // Where a packet-ID byte leads: timing packets are parsed, framing bytes give up, others are skipped.
   function automatic tsip_state_t id_next(input logic [7:0] b);
      if (b == TSIP_ID_TIMING)        return ST_BODY;
      else if (b == DLE || b == ETX)  return ST_IDLE;
      else                            return ST_SKIP;
   endfunction

   // After a DLE, the data byte is always the received byte (DLE,DLE collapses to 0x10).
   assign o_data    = i_rx_byte;
   assign o_busy    = (r_state != ST_IDLE);
   assign o_in_body = (r_state == ST_BODY) || (r_state == ST_BODY_DLE);

   // State register.
   always_ff @(posedge i_clk) begin
      if (i_rst) r_state <= ST_IDLE;
      else       r_state <= w_state_nxt;
   end

   // Next-state and per-byte strobes.
   always_comb begin
      w_state_nxt = r_state;
      o_data_dv   = 1'b0;
      o_sof       = 1'b0;
      o_eof       = 1'b0;
      o_err       = 1'b0;
      if (i_abort) begin
         w_state_nxt = ST_IDLE;
      end else if (i_rx_dv) begin
         case (r_state)
            ST_IDLE: begin
               if (i_rx_byte == DLE) w_state_nxt = ST_ID;
            end
            ST_ID: begin
               w_state_nxt = id_next(i_rx_byte);
               o_sof       = (i_rx_byte == TSIP_ID_TIMING);
            end
            ST_BODY: begin
               if (i_rx_byte == DLE) w_state_nxt = ST_BODY_DLE;
               else                  o_data_dv   = 1'b1;
            end
            ST_BODY_DLE: begin
               if (i_rx_byte == DLE) begin
                  o_data_dv   = 1'b1;
                  w_state_nxt = ST_BODY;
               end else if (i_rx_byte == ETX) begin
                  o_eof       = 1'b1;
                  w_state_nxt = ST_IDLE;
               end else begin
                  // Lone DLE inside a body: the old frame is broken, this byte starts a new one.
                  o_err       = 1'b1;
                  o_sof       = (i_rx_byte == TSIP_ID_TIMING);
                  w_state_nxt = id_next(i_rx_byte);
               end
            end
            ST_SKIP: begin
               if (i_rx_byte == DLE) w_state_nxt = ST_SKIP_DLE;
            end
            ST_SKIP_DLE: begin
               if (i_rx_byte == DLE)      w_state_nxt = ST_SKIP;
               else if (i_rx_byte == ETX) w_state_nxt = ST_IDLE;
               else begin
                  o_sof       = (i_rx_byte == TSIP_ID_TIMING);
                  w_state_nxt = id_next(i_rx_byte);
               end
            end
            default: w_state_nxt = ST_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/thunder_timing_decoder.sv
// Purpose: extracts TSIP Primary Timing (0x8F-AB) time fields; optional THUNDER_RANGE_CHECK_EN adds calendar checks.
// Latency: packet_dv / frame_err one clock after the ETX (or aborting) byte strobe.
// Backpressure: none; bytes accepted every cycle, inter-byte stall of TIMEOUT_CLKS aborts the frame.
module thunder_timing_decoder
   import thunder_pkg::*;
#(
   parameter int TIMEOUT_CLKS = 100000
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_rx_dv,
   input  logic [7:0]  i_rx_byte,
   output logic        o_thunder_packet_dv,
   output logic [15:0] o_thunder_year,
   output logic [7:0]  o_thunder_month,
   output logic [7:0]  o_thunder_day,
   output logic [7:0]  o_thunder_hour,
   output logic [7:0]  o_thunder_minutes,
   output logic [7:0]  o_thunder_seconds,
   output logic        o_frame_err
);

   localparam int TMO_W = $clog2(TIMEOUT_CLKS + 1);

   logic          w_data_dv, w_sof, w_eof, w_err, w_busy, w_in_body;
   logic [7:0]    w_data;
   logic          w_timeout, w_range_ok, w_is_primary, w_eof_ok, w_eof_bad;

   logic [4:0]       r_idx;
   logic [7:0]       r_sub;
   thunder_time_t    r_shadow;
   thunder_time_t    r_time;
   logic [TMO_W-1:0] r_tmo_cnt;
   logic             r_packet_dv;
   logic             r_frame_err;

   tsip_frame_unstuffer u_unstuffer (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_rx_dv   (i_rx_dv),
      .i_rx_byte (i_rx_byte),
      .i_abort   (w_timeout),
      .o_data_dv (w_data_dv),
      .o_data    (w_data),
      .o_sof     (w_sof),
      .o_eof     (w_eof),
      .o_err     (w_err),
      .o_busy    (w_busy),
      .o_in_body (w_in_body)
   );

   // A byte arriving in the same cycle always wins over the timeout, so strobes never collide.
   assign w_timeout = w_busy && !i_rx_dv && (r_tmo_cnt == TMO_W'(TIMEOUT_CLKS - 1));

`ifdef THUNDER_RANGE_CHECK_EN
   assign w_range_ok = time_in_range(r_shadow);
`else
   assign w_range_ok = 1'b1;
`endif

   // Other 0x8F subcodes end quietly; only a primary timing frame is judged.
   assign w_is_primary = (r_sub == TSIP_SUB_PRIMARY);
   assign w_eof_ok     = w_eof && w_is_primary && (r_idx == 5'(PRIMARY_LEN)) && w_range_ok;
   assign w_eof_bad    = w_eof && w_is_primary && !((r_idx == 5'(PRIMARY_LEN)) && w_range_ok);

   // Inter-byte idle counter, only running while a frame is open.
   always_ff @(posedge i_clk) begin
      if (i_rst || !w_busy || i_rx_dv || w_timeout) r_tmo_cnt <= '0;
      else                                          r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
   end

   // Payload index and shadow capture of the fields of interest.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_idx    <= '0;
         r_sub    <= '0;
         r_shadow <= '0;
      end else if (w_sof) begin
         r_idx <= '0;
      end else if (w_data_dv) begin
         case (r_idx)
            5'(OFS_SUB):     r_sub              <= w_data;
            5'(OFS_SEC):     r_shadow.seconds   <= w_data;
            5'(OFS_MIN):     r_shadow.minutes   <= w_data;
            5'(OFS_HOUR):    r_shadow.hour      <= w_data;
            5'(OFS_DAY):     r_shadow.day       <= w_data;
            5'(OFS_MONTH):   r_shadow.month     <= w_data;
            5'(OFS_YEAR_HI): r_shadow.year[15:8] <= w_data;
            5'(OFS_YEAR_LO): r_shadow.year[7:0]  <= w_data;
            default: ;
         endcase
         if (r_idx != 5'(IDX_MAX)) r_idx <= r_idx + 5'd1;
      end
   end

   // Publish all fields at once on a good frame; raise a single error strobe otherwise.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_time      <= '0;
         r_packet_dv <= 1'b0;
         r_frame_err <= 1'b0;
      end else begin
         r_packet_dv <= w_eof_ok;
         r_frame_err <= w_eof_bad || w_err || (w_timeout && w_in_body);
         if (w_eof_ok) r_time <= r_shadow;
      end
   end

   assign o_thunder_packet_dv = r_packet_dv;
   assign o_frame_err         = r_frame_err;
   assign o_thunder_year      = r_time.year;
   assign o_thunder_month     = r_time.month;
   assign o_thunder_day       = r_time.day;
   assign o_thunder_hour      = r_time.hour;
   assign o_thunder_minutes   = r_time.minutes;
   assign o_thunder_seconds   = r_time.seconds;

endmodule

// File: tb/tb_thunder_timing_decoder.sv
// Purpose: directed-vector scoreboard bench for thunder_timing_decoder (THUNDER_RANGE_CHECK_EN aware).
// Latency: expects each strobe exactly one clock after its triggering byte, timeout after TMO idle clocks.
// Backpressure: none; bytes are driven back-to-back or with fixed gaps.
module tb_thunder_timing_decoder;

   localparam int TMO = 40;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rx_dv = 1'b0;
   logic [7:0]  rx_byte = 8'h00;
   logic        pkt_dv, frame_err;
   logic [15:0] year;
   logic [7:0]  month, day, hour, minutes, seconds;

   thunder_timing_decoder #(.TIMEOUT_CLKS(TMO)) dut (
      .i_clk               (clk),
      .i_rst               (rst),
      .i_rx_dv             (rx_dv),
      .i_rx_byte           (rx_byte),
      .o_thunder_packet_dv (pkt_dv),
      .o_thunder_year      (year),
      .o_thunder_month     (month),
      .o_thunder_day       (day),
      .o_thunder_hour      (hour),
      .o_thunder_minutes   (minutes),
      .o_thunder_seconds   (seconds),
      .o_frame_err         (frame_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      bit          pkt;
      logic [15:0] year;
      logic [7:0]  mon, day, hr, mi, sec;
      int          at;
   } ev_t;

   ev_t         exp_q[$];
   int          checks = 0;
   int          errors = 0;
   logic [7:0]  pl [0:16];
   int          gap = 0;
   logic [15:0] cur_year = 16'd0;
   logic [7:0]  cur_mon = 8'd0, cur_day = 8'd0, cur_hr = 8'd0, cur_mi = 8'd0, cur_sec = 8'd0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // kind: 1 = packet expected from current pl, 2 = frame error expected.
   task automatic push_exp(input int kind, input int at);
      ev_t e;
      e.pkt  = (kind == 1);
      e.year = {pl[15], pl[16]};
      e.mon  = pl[14];
      e.day  = pl[13];
      e.hr   = pl[12];
      e.mi   = pl[11];
      e.sec  = pl[10];
      e.at   = at;
      exp_q.push_back(e);
      if (e.pkt) begin
         cur_year = e.year; cur_mon = e.mon; cur_day = e.day;
         cur_hr = e.hr; cur_mi = e.mi; cur_sec = e.sec;
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk); #1;
         rx_dv = 1'b0;
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input int kind);
      @(posedge clk); #1;
      rx_dv   = 1'b1;
      rx_byte = b;
      if (kind != 0) push_exp(kind, cyc + 1);
      if (gap > 0) idle(gap);
   endtask

   task automatic send_payload(input int n);
      for (int i = 0; i < n; i++) begin
         if (pl[i] == 8'h10) send_byte(8'h10, 0);
         send_byte(pl[i], 0);
      end
   endtask

   task automatic send_frame(input logic [7:0] id, input int n, input int kind);
      send_byte(8'h10, 0);
      send_byte(id, 0);
      send_payload(n);
      send_byte(8'h10, 0);
      send_byte(8'h03, kind);
   endtask

   task automatic load_base();
      pl[0] = 8'hAB;
      for (int i = 1; i < 10; i++) pl[i] = 8'h00;
      pl[10] = 8'h1C; pl[11] = 8'h37; pl[12] = 8'h0B; pl[13] = 8'h0F;
      pl[14] = 8'h07; pl[15] = 8'h07; pl[16] = 8'hE4;
   endtask

   task automatic check_hold(input string tag);
      check({tag, "_year"}, year, cur_year);
      check({tag, "_month"}, month, cur_mon);
      check({tag, "_day"}, day, cur_day);
      check({tag, "_hour"}, hour, cur_hr);
      check({tag, "_min"}, minutes, cur_mi);
      check({tag, "_sec"}, seconds, cur_sec);
   endtask

   // Monitor: every strobe must match the oldest expected event, including its cycle.
   always @(negedge clk) begin
      ev_t e;
      if (!rst && (pkt_dv || frame_err)) begin
         check("exclusive", {31'd0, pkt_dv && frame_err}, 32'd0);
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_strobe actual pkt=%0b err=%0b required none", pkt_dv, frame_err);
         end else begin
            e = exp_q.pop_front();
            check("kind_pkt", {31'd0, pkt_dv}, {31'd0, e.pkt});
            check("strobe_cycle", cyc, e.at);
            if (e.pkt) begin
               check("year", year, e.year);
               check("month", month, e.mon);
               check("day", day, e.day);
               check("hour", hour, e.hr);
               check("minutes", minutes, e.mi);
               check("seconds", seconds, e.sec);
            end
         end
      end
   end

   initial begin
      idle(3);
      rst = 1'b0;
      #1;
      check("rst_pkt_dv", {31'd0, pkt_dv}, 32'd0);
      check("rst_frame_err", {31'd0, frame_err}, 32'd0);
      check_hold("rst");

      // 2020-07-15 11:55:28, back-to-back bytes.
      load_base();
      send_frame(8'h8F, 17, 1);
      idle(4);

      // Seconds = 0x10 sent stuffed; still 17 payload bytes.
      pl[10] = 8'h10;
      send_frame(8'h8F, 17, 1);
      idle(4);

      // Other subcode and other packet ID: silently ignored, outputs hold.
      load_base();
      pl[0] = 8'hAC;
      send_frame(8'h8F, 17, 0);
      pl[0] = 8'hAB;
      send_frame(8'h47, 17, 0);
      idle(5);
      check_hold("hold_other");

      // Truncated to 16 payload bytes.
      send_frame(8'h8F, 16, 2);
      idle(4);
      check_hold("hold_trunc");

      // Stall after payload byte 8, then a fresh valid frame.
      send_byte(8'h10, 0);
      send_byte(8'h8F, 0);
      send_payload(8);
      push_exp(2, cyc + 1 + TMO);
      idle(TMO + 5);
      check_hold("hold_tmo");
      pl[10] = 8'h2A;
      send_frame(8'h8F, 17, 1);
      idle(4);

      // Lone DLE followed by a new 0x8F ID mid-body: error, then new frame parses.
      load_base();
      pl[11] = 8'h01;
      send_byte(8'h10, 0);
      send_byte(8'h8F, 0);
      send_payload(5);
      send_byte(8'h10, 0);
      send_byte(8'h8F, 2);
      send_payload(17);
      send_byte(8'h10, 0);
      send_byte(8'h03, 1);
      idle(4);

      // Month out of range.
      load_base();
      pl[14] = 8'd13;
`ifdef THUNDER_RANGE_CHECK_EN
      send_frame(8'h8F, 17, 2);
`else
      send_frame(8'h8F, 17, 1);
`endif
      idle(4);
      pl[14] = 8'd7;
      send_frame(8'h8F, 17, 1);
      idle(4);

      // Reset mid-frame: discarded, no strobes, outputs cleared.
      send_byte(8'h10, 0);
      send_byte(8'h8F, 0);
      send_payload(5);
      @(posedge clk); #1;
      rx_dv = 1'b0;
      rst   = 1'b1;
      idle(2);
      rst = 1'b0;
      cur_year = 16'd0; cur_mon = 8'd0; cur_day = 8'd0;
      cur_hr = 8'd0; cur_mi = 8'd0; cur_sec = 8'd0;
      idle(3);
      check_hold("mid_rst");

      // Bytes with gaps shorter than the timeout.
      pl[12] = 8'd23;
      gap = 3;
      send_frame(8'h8F, 17, 1);
      gap = 0;
      idle(10);

      check("queue_empty", exp_q.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
